// File: rtl/fetch_unit_if.sv
// Fetch unit bundle.
// Groups the redirect input, the instruction-memory request/response channel
// and the decode-side instruction channel into one interface.
// The master modport is the fetch unit; the slave modport is its surroundings.
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the PC and issues word-aligned fetches under a credit limit. Each
// in-flight fetch address is remembered in an address queue, so a returning
// word can be paired with its PC in the instruction FIFO feeding decode.
// A redirect flushes the FIFO and arranges for every fetch still in flight
// to be discarded when it returns.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   aq_addr_q [FIFO_DEPTH];
    logic [AW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];
    logic [AW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
    logic [CW-1:0] f_cnt_q, f_cnt_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW:0]   credit_used;
    logic          req_fire, rsp_push, inst_pop;

    // In-flight fetches plus buffered words never exceed the FIFO depth, so
    // every response is guaranteed a FIFO slot.
    assign credit_used        = {1'b0, outstanding_q} + {1'b0, f_cnt_q};
    assign bus.imem_req_valid = !rst && !bus.redirect && (credit_used < {1'b0, DEPTH_C});
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (f_cnt_q != '0) && !bus.redirect;
    assign bus.inst           = fifo_inst_q[f_rd_q];
    assign bus.inst_pc        = fifo_pc_q[f_rd_q];

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_push = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect;
    assign inst_pop = bus.inst_valid && bus.inst_ready;

    // Next-state for the PC, queue pointers and counters; redirect overrides all.
    always_comb begin
        pc_d          = pc_q;
        aq_rd_d       = aq_rd_q;
        aq_wr_d       = aq_wr_q;
        f_rd_d        = f_rd_q;
        f_wr_d        = f_wr_q;
        f_cnt_d       = f_cnt_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        if (req_fire) begin
            pc_d          = pc_q + 32'd4;
            aq_wr_d       = aq_wr_q + AW'(1);
            outstanding_d = outstanding_d + CW'(1);
        end
        if (bus.imem_rsp_valid) begin
            aq_rd_d       = aq_rd_q + AW'(1);
            outstanding_d = outstanding_d - CW'(1);
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
        if (rsp_push) begin
            f_wr_d  = f_wr_q + AW'(1);
            f_cnt_d = f_cnt_d + CW'(1);
        end
        if (inst_pop) begin
            f_rd_d  = f_rd_q + AW'(1);
            f_cnt_d = f_cnt_d - CW'(1);
        end
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
            f_rd_d     = '0;
            f_wr_d     = '0;
            f_cnt_d    = '0;
            drop_cnt_d = outstanding_q - (bus.imem_rsp_valid ? CW'(1) : CW'(0));
        end
    end

    // State registers and queue storage, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            aq_rd_q       <= '0;
            aq_wr_q       <= '0;
            f_rd_q        <= '0;
            f_wr_q        <= '0;
            f_cnt_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                aq_addr_q[i]   <= '0;
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            aq_rd_q       <= aq_rd_d;
            aq_wr_q       <= aq_wr_d;
            f_rd_q        <= f_rd_d;
            f_wr_q        <= f_wr_d;
            f_cnt_q       <= f_cnt_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            if (req_fire) begin
                aq_addr_q[aq_wr_q] <= pc_q;
            end
            if (rsp_push) begin
                fifo_pc_q[f_wr_q]   <= aq_addr_q[aq_rd_q];
                fifo_inst_q[f_wr_q] <= bus.imem_rsp_data;
            end
        end
    end

    // A response with nothing in flight means the memory broke the protocol.
    rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit.
// A queue-based reference model (in-flight fetches tagged stale on redirect,
// buffered words in a plain queue) predicts every output each cycle, while a
// memory model answers accepted fetches in order with random latency.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    typedef struct {logic [31:0] addr; bit stale;} flight_t;
    typedef struct {logic [31:0] pc; logic [31:0] data;} entry_t;
    typedef struct {int due; logic [31:0] data;} memrsp_t;

    logic clk;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    flight_t     flightQ[$];
    entry_t      instQ[$];
    memrsp_t     memQ[$];
    logic [31:0] pcM;
    int          cyc, lastDue;
    int          checks, failures;
    int          reqRdyPct, instRdyPct, redirPct, latMin, latMax;
    bit          forceRedir;
    logic [31:0] forcePc;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        flightQ.delete();
        instQ.delete();
        memQ.delete();
        pcM     = RESET_PC;
        lastDue = 0;
    endtask

    // Drive this cycle's inputs, including the memory's in-order responses.
    task automatic applyStimulus();
        cyc++;
        bus.redirect       = forceRedir ? 1'b1 : ($urandom_range(99) < redirPct);
        bus.redirect_pc    = forceRedir ? forcePc : $urandom;
        bus.imem_req_ready = ($urandom_range(99) < reqRdyPct);
        bus.inst_ready     = ($urandom_range(99) < instRdyPct);
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memQ[0].data;
            void'(memQ.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
    endtask

    // Compare outputs against the model, then advance the model one cycle.
    task automatic checkOutput();
        bit      expReqV, expInstV, reqFire;
        flight_t f;
        int      lat, due;
        expReqV  = !bus.redirect && ((flightQ.size() + instQ.size()) < DEPTH);
        expInstV = (instQ.size() > 0) && !bus.redirect;
        chk("req_valid", 32'(bus.imem_req_valid), 32'(expReqV));
        if (expReqV) chk("req_addr", bus.imem_req_addr, pcM);
        chk("inst_valid", 32'(bus.inst_valid), 32'(expInstV));
        if (expInstV) begin
            chk("inst", bus.inst, instQ[0].data);
            chk("inst_pc", bus.inst_pc, instQ[0].pc);
        end
        reqFire = expReqV && bus.imem_req_ready;
        if (expInstV && bus.inst_ready) void'(instQ.pop_front());
        if (bus.imem_rsp_valid && flightQ.size() > 0) begin
            f = flightQ.pop_front();
            if (!f.stale && !bus.redirect) instQ.push_back('{pc: f.addr, data: bus.imem_rsp_data});
        end
        if (reqFire) begin
            flightQ.push_back('{addr: pcM, stale: 1'b0});
            lat = $urandom_range(latMax, latMin);
            due = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
            lastDue = due;
            memQ.push_back('{due: due, data: $urandom});
            pcM = pcM + 32'd4;
        end
        if (bus.redirect) begin
            instQ.delete();
            foreach (flightQ[i]) flightQ[i].stale = 1'b1;
            pcM = bus.redirect_pc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic stepCycle(input bit releaseRst);
        @(negedge clk);
        if (releaseRst) rst = 1'b0;
        applyStimulus();
        #1;
        checkOutput();
        forceRedir = 1'b0;
    endtask

    task automatic setKnobs(input int rq, input int ir, input int rd, input int lmin, input int lmax);
        reqRdyPct  = rq;
        instRdyPct = ir;
        redirPct   = rd;
        latMin     = lmin;
        latMax     = lmax;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        forceRedir = 1'b0;
        forcePc    = '0;
        rst        = 1'b1;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        modelReset();
        setKnobs(100, 100, 0, 1, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);

        // Streaming from reset: one fetch and, from the third cycle, one instruction per cycle.
        for (int k = 1; k <= 8; k++) begin
            stepCycle(k == 1);
            chk("p1_addr", bus.imem_req_addr, RESET_PC + 32'((k - 1) * 4));
            if (k >= 3) begin
                chk("p1_inst_valid", 32'(bus.inst_valid), 32'd1);
                chk("p1_inst_pc", bus.inst_pc, RESET_PC + 32'((k - 3) * 4));
            end
        end

        // Decode stalls: credit runs out, then the buffer drains in order.
        setKnobs(100, 0, 0, 1, 1);
        repeat (8) stepCycle(0);
        chk("p2_credit_stall", 32'(bus.imem_req_valid), 32'd0);
        setKnobs(100, 100, 0, 1, 1);
        repeat (8) stepCycle(0);

        // Memory refuses requests: address must hold steady.
        setKnobs(0, 100, 0, 1, 1);
        repeat (5) stepCycle(0);
        setKnobs(100, 100, 0, 1, 1);
        repeat (4) stepCycle(0);

        // Redirect with fetches in flight to an unaligned target.
        setKnobs(100, 100, 0, 3, 3);
        repeat (6) stepCycle(0);
        forceRedir = 1'b1;
        forcePc    = 32'h0000_0103;
        stepCycle(0);
        stepCycle(0);
        chk("p4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("p4_req_addr", bus.imem_req_addr, 32'h0000_0100);
        repeat (8) stepCycle(0);

        // Redirect coinciding with a response and a decode pop.
        setKnobs(100, 100, 0, 1, 1);
        repeat (6) stepCycle(0);
        forceRedir = 1'b1;
        forcePc    = 32'h0000_0200;
        stepCycle(0);
        stepCycle(0);
        chk("p5_flushed", 32'(bus.inst_valid), 32'd0);
        repeat (6) stepCycle(0);

        // PC wraps past the top of the address space.
        forceRedir = 1'b1;
        forcePc    = 32'hFFFF_FFF9;
        stepCycle(0);
        repeat (8) stepCycle(0);

        // Randomized traffic with varying latency, backpressure and redirects.
        for (int b = 0; b < 8; b++) begin
            setKnobs($urandom_range(100, 30), $urandom_range(100, 30),
                     $urandom_range(10, 0), 1, $urandom_range(4, 1));
            repeat (50) stepCycle(0);
        end

        // Asynchronous reset with several buffered entries.
        setKnobs(100, 0, 0, 1, 1);
        for (int i = 0; i < 20 && instQ.size() < 3; i++) stepCycle(0);
        if (instQ.size() < 3) begin
            checks++;
            failures++;
            $error("[TB] FAIL fill_budget: observed %0d entries expected at least 3", instQ.size());
        end
        @(negedge clk);
        bus.redirect       = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("async_inst_pc", bus.inst_pc, 32'd0);
        modelReset();
        @(posedge clk);
        setKnobs(100, 100, 0, 1, 1);
        stepCycle(1);
        chk("post_rst_addr", bus.imem_req_addr, RESET_PC);
        repeat (10) stepCycle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of decode. It owns the PC and issues word-aligned requests to instruction memory over a valid/ready handshake. Returned instruction words are buffered with their PCs in an in-order FIFO and presented to decode over a valid/ready interface. It accepts redirects from branch/jump resolution, which flush buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
FIFO_DEPTH, 4, instruction buffer entries; power of two, >=2; also the credit limit on in-flight requests

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new PC; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address; always word aligned
imem_rsp_valid  in  1  response word valid; in order; no backpressure
imem_rsp_data  in  32  instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  instruction word to decode
inst_pc  out  32  PC of inst

Behaviour:
- Reset (async, immediate): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- State: pc reg; address queue (FIFO_DEPTH entries, address per in-flight request); instruction FIFO {pc,inst}; outstanding counter; drop_cnt counter.
- Credit: imem_req_valid = !redirect && (outstanding + fifo_count) < FIFO_DEPTH. imem_req_addr = pc. A response therefore always finds FIFO space.
- Request handshake (valid&ready): push pc into address queue; pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0); outstanding++.
- imem_req_valid may deassert without handshake only on credit exhaustion or redirect. While it stays high, imem_req_addr holds stable.
- Response with drop_cnt==0: pop address queue, push {addr, imem_rsp_data} into FIFO, outstanding--.
- Response with drop_cnt>0: discard, pop address queue, drop_cnt--, outstanding--.
- Output is registered FIFO head. inst_valid = !empty && !redirect. Pop on inst_valid&inst_ready. A response in cycle N is visible on inst/inst_pc no earlier than cycle N+1.
- Simultaneous response push and decode pop: both occur; count unchanged.
- Redirect (highest priority), same cycle:
  - pc <= {redirect_pc[31:2],2'b00}; FIFO flushed; no request issued; inst_valid forced 0, so no pop.
  - drop_cnt <= outstanding minus 1 if a response is accepted this cycle; that response is discarded.
  - Next cycle, a request for the new pc if credit allows.
- Back-to-back redirects: the last one wins; drop_cnt recomputed each time.
- Throughput: with 1-cycle memory latency, imem_req_ready=1 and inst_ready=1, one instruction per cycle in steady state.
- Response with outstanding==0 is illegal; flag it with an assertion.

Test Plan:
1. Reset release, imem_req_ready=1, 1-cycle response latency, inst_ready=1 -> imem_req_addr 0,4,8,C on consecutive cycles; inst_pc 0,4,8,C one per cycle from the 3rd cycle after reset.
2. inst_ready=0 -> exactly 4 requests issued, then imem_req_valid=0; FIFO holds PCs 0..C. Raise inst_ready -> PCs drain in order, requests resume at 0x10.
3. imem_req_ready=0 for 5 cycles with imem_req_valid=1 -> imem_req_addr held at same value, pc unchanged, no FIFO push.
4. Two requests in flight (0x20,0x24), redirect=1 with redirect_pc=0x103 -> both responses discarded, next request and first inst_pc = 0x100.
5. Redirect in the same cycle as a response and inst_valid&inst_ready -> response discarded, no pop, FIFO empty next cycle, drop_cnt = outstanding-1.
6. rst asserted mid-stream with 3 buffered entries -> inst_valid and imem_req_valid go 0 without a clock edge. After release, first imem_req_addr = RESET_PC.
